// File: rtl/sauria_eoc_pkg.sv
// rtl/sauria_eoc_pkg.sv - shared types and register map for the end-of-computation unit
package sauria_eoc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    // Word indices (byte offset >> 2) inside the unit's 64-byte window
    localparam logic [3:0] IDX_CTRL   = 4'd0;
    localparam logic [3:0] IDX_STATUS = 4'd1;
    localparam logic [3:0] IDX_EXIT   = 4'd2;
    localparam logic [3:0] IDX_LIMIT  = 4'd3;
    localparam logic [3:0] IDX_COUNT  = 4'd4;
    localparam logic [3:0] IDX_KICK   = 4'd5;

    localparam int unsigned CTRL_START_BIT     = 0;
    localparam int unsigned CTRL_CLEAR_BIT     = 1;
    localparam int unsigned STATUS_EOC_BIT     = 0;
    localparam int unsigned STATUS_TIMEOUT_BIT = 1;
    localparam int unsigned STATUS_RUNNING_BIT = 2;

endpackage

// File: rtl/sauria_eoc_unit.sv
// rtl/sauria_eoc_unit.sv - end-of-computation register block with exit-code latch and heartbeat watchdog
module sauria_eoc_unit
    import sauria_eoc_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic                 eoc_o,
    output logic [30:0]          exit_code_o,
    output logic                 timeout_o,
    output logic                 irq_o
);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [CntWidth-1:0] limit_q, limit_d;
    logic [30:0]         code_q, code_d;
    logic                rsp_valid_q, rsp_error_q, irq_q;
    logic [31:0]         rsp_rdata_q, rdata_d;

    logic       accept, mapped, wr;
    logic [3:0] widx;
    logic       do_start, do_clear, do_exit, do_kick, wr_limit;
    logic       finished, timeout_hit;
    logic       unused_addr;

    assign req_ready_o = !rsp_valid_q;
    assign accept      = req_valid_i && !rsp_valid_q;
    assign widx        = req_addr_i[5:2];
    assign mapped      = (widx <= IDX_KICK);
    assign wr          = accept && req_write_i && mapped;

    assign do_start = wr && (widx == IDX_CTRL) && req_wdata_i[CTRL_START_BIT];
    assign do_clear = wr && (widx == IDX_CTRL) && req_wdata_i[CTRL_CLEAR_BIT];
    assign do_exit  = wr && (widx == IDX_EXIT) && req_wdata_i[0];
    assign do_kick  = wr && (widx == IDX_KICK);
    assign wr_limit = wr && (widx == IDX_LIMIT);

    assign finished    = (state_q == DONE) || (state_q == TIMEOUT);
    // A kick landing on the expiry cycle rescues the program
    assign timeout_hit = (limit_q != '0) && (count_q >= limit_q - CntWidth'(1)) && !do_kick;

    assign unused_addr = ^{req_addr_i[AddrWidth-1:6], req_addr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (do_exit)       state_d = DONE;
                else if (do_start) state_d = RUN;
            end
            RUN: begin
                if (do_exit)          state_d = DONE;
                else if (timeout_hit) state_d = TIMEOUT;
            end
            DONE, TIMEOUT: begin
                if (do_clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eoc_o     = (state_q == DONE);
        timeout_o = (state_q == TIMEOUT);
    end

    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        code_d  = code_q;
        if (wr_limit) limit_d = req_wdata_i[CntWidth-1:0];
        if (finished && do_clear) begin
            count_d = '0;
            code_d  = '0;
        end else if (do_kick) begin
            count_d = '0;
        end else if ((state_q == RUN) && (state_d == RUN) && (count_q != '1)) begin
            count_d = count_q + CntWidth'(1);
        end
        if (!finished && do_exit) code_d = req_wdata_i[31:1];
    end

    always_comb begin
        rdata_d = '0;
        if (accept && !req_write_i) begin
            case (widx)
                IDX_STATUS: begin
                    rdata_d[STATUS_EOC_BIT]     = (state_q == DONE);
                    rdata_d[STATUS_TIMEOUT_BIT] = (state_q == TIMEOUT);
                    rdata_d[STATUS_RUNNING_BIT] = (state_q == RUN);
                end
                IDX_EXIT:  rdata_d = {code_q, state_q == DONE};
                IDX_LIMIT: rdata_d = 32'(limit_q);
                IDX_COUNT: rdata_d = 32'(count_q);
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= '0;
            limit_q     <= '0;
            code_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            limit_q     <= limit_d;
            code_q      <= code_d;
            rsp_valid_q <= accept;
            rsp_error_q <= accept && !mapped;
            rsp_rdata_q <= rdata_d;
            irq_q       <= (state_d != state_q) && ((state_d == DONE) || (state_d == TIMEOUT));
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_error_o = rsp_error_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign exit_code_o = code_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_sauria_eoc_unit.sv
// tb/tb_sauria_eoc_unit.sv - self-checking bench for sauria_eoc_unit
module tb_sauria_eoc_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic        eoc_o;
    logic [30:0] exit_code_o;
    logic        timeout_o;
    logic        irq_o;

    sauria_eoc_unit #(.AddrWidth(32), .CntWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
        .eoc_o(eoc_o), .exit_code_o(exit_code_o), .timeout_o(timeout_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples of the response cycle and the cycle after it
    logic        r_valid, r_err, r_eoc, r_to, r_irq, r_irq2, r_ready;
    logic [31:0] r_data;

    // One request followed by one idle cycle; starts and ends #1 after a rising edge
    task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d);
        req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = d;
        @(posedge clk_i); #1;
        r_valid = rsp_valid_o; r_err = rsp_error_o; r_data = rsp_rdata_o;
        r_eoc = eoc_o; r_to = timeout_o; r_irq = irq_o; r_ready = req_ready_o;
        req_valid_i = 1'b0; req_write_i = 1'b0;
        @(posedge clk_i); #1;
        r_irq2 = irq_o;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] er;
        bit          eerr;
        bit          eeoc;
        bit          eirq;
    } vec_t;
    vec_t tbl[24];

    // Reference model: program outcome flags, exit code and a plain integer heartbeat counter
    bit          m_done, m_to, m_run;
    longint      m_count, m_limit;
    logic [30:0] m_code;
    bit          e_rv, e_err, e_irq;
    logic [31:0] e_rd;

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            1:       return {29'd0, m_run, m_to, m_done};
            2:       return {m_code, m_done};
            3:       return m_limit[31:0];
            4:       return m_count[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
        int  idx;
        bit  ok, was_over, kick, start, clr, ex;
        idx = int'(a[5:2]);
        ok  = (idx <= 5);
        e_rv  = v;
        e_err = v && !ok;
        e_rd  = (v && !w && ok) ? m_read(idx) : 32'd0;
        kick  = v && w && ok && idx == 5;
        start = v && w && ok && idx == 0 && d[0];
        clr   = v && w && ok && idx == 0 && d[1];
        ex    = v && w && ok && idx == 2 && d[0];
        was_over = m_done || m_to;
        if (was_over) begin
            if (clr) begin m_done = 0; m_to = 0; m_count = 0; m_code = '0; end
        end else if (ex) begin
            m_done = 1; m_run = 0; m_code = d[31:1];
        end else if (m_run) begin
            if (!kick && m_limit != 0 && m_count + 1 >= m_limit) begin
                m_to = 1; m_run = 0;
            end else if (m_count < 64'hFFFF_FFFF) begin
                m_count = m_count + 1;
            end
        end else if (start) begin
            m_run = 1;
        end
        if (kick) m_count = 0;
        if (v && w && ok && idx == 3) m_limit = longint'({32'd0, d});
        e_irq = !was_over && (m_done || m_to);
    endtask

    task automatic rcycle(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
        req_valid_i = v; req_write_i = w; req_addr_i = a; req_wdata_i = d;
        @(posedge clk_i);
        m_step(v, w, a, d);
        #1;
        req_valid_i = 1'b0; req_write_i = 1'b0;
        check("random_cycle",
              {req_ready_o, rsp_valid_o, rsp_valid_o ? {rsp_error_o, rsp_rdata_o} : 33'd0,
               eoc_o, timeout_o, irq_o, exit_code_o},
              {!e_rv, e_rv, e_err, e_rd, m_done, m_to, e_irq, m_code});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        bit saw_to;

        tbl[0]  = '{1'b0, 32'h04, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0C, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h10, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'h08, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 32'h20, 32'h0,        32'h0,  1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h18, 32'hFFFFFFFF, 32'h0,  1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h04, 32'hFF,       32'h0,  1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 32'h10, 32'h1234,     32'h0,  1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'h10, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h08, 32'hFFFFFFFE, 32'h0,  1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h04, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'h08, 32'h1,        32'h0,  1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 32'h04, 32'h0,        32'h1,  1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 32'h08, 32'h0,        32'h1,  1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 32'h08, 32'hB,        32'h0,  1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 32'h08, 32'h0,        32'h1,  1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 32'h00, 32'h1,        32'h0,  1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 32'h04, 32'h0,        32'h1,  1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 32'h00, 32'h3,        32'h0,  1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 32'h04, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 32'h0C, 32'h55,       32'h0,  1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 32'h0C, 32'h0,        32'h55, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 32'h00, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 32'h14, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("reset_outputs", {req_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o, eoc_o, timeout_o, irq_o, exit_code_o},
              {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 31'd0});

        for (int i = 0; i < 24; i++) begin
            bus(tbl[i].w, tbl[i].a, tbl[i].d);
            check($sformatf("vector_%0d", i), {r_valid, r_err, r_data, r_eoc, r_irq, r_irq2},
                  {1'b1, tbl[i].eerr, tbl[i].er, tbl[i].eeoc, tbl[i].eirq, 1'b0});
        end
        check("exit_code_zero", exit_code_o, 31'd0);

        // Watchdog expiry exactly 100 cycles after RUN entry
        bus(1'b1, 32'h0C, 32'd100);
        bus(1'b1, 32'h00, 32'h1);
        cyc = 1;
        while (!timeout_o && cyc < 300) begin @(posedge clk_i); #1; cyc++; end
        check("timeout_latency", cyc, 100);
        check("timeout_irq", irq_o, 1'b1);
        bus(1'b0, 32'h10, 32'h0);
        check("timeout_count", {r_irq, r_data}, {1'b0, 32'd99});
        bus(1'b0, 32'h04, 32'h0);
        check("timeout_status", r_data, 32'h2);

        // Kicked every 50 cycles: never expires, then exits with code 5
        bus(1'b1, 32'h00, 32'h2);
        check("clear_status", {eoc_o, timeout_o}, 2'b00);
        bus(1'b1, 32'h00, 32'h1);
        saw_to = 1'b0;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < 48; j++) begin @(posedge clk_i); #1; saw_to |= timeout_o; end
            bus(1'b1, 32'h14, 32'h0);
            saw_to |= r_to | timeout_o;
        end
        check("kick_no_timeout", saw_to, 1'b0);
        bus(1'b1, 32'h08, (32'd5 << 1) | 32'd1);
        check("kick_exit", {r_eoc, r_to, r_irq, exit_code_o}, {1'b1, 1'b0, 1'b1, 31'd5});

        // EXIT lands on the very cycle the watchdog would fire
        bus(1'b1, 32'h00, 32'h2);
        bus(1'b1, 32'h0C, 32'd10);
        bus(1'b1, 32'h00, 32'h1);
        idle(8);
        bus(1'b1, 32'h08, 32'hF);
        check("exit_vs_timeout", {r_eoc, r_to, r_irq, exit_code_o}, {1'b1, 1'b0, 1'b1, 31'd7});
        idle(20);
        check("exit_vs_timeout_hold", {eoc_o, timeout_o}, 2'b10);
        bus(1'b1, 32'h00, 32'h2);
        check("clear_all", {eoc_o, timeout_o, irq_o, exit_code_o}, 34'd0);
        bus(1'b0, 32'h04, 32'h0);
        check("clear_status_read", r_data, 32'h0);

        // Lowering the limit below the running count expires on the following cycle
        bus(1'b1, 32'h0C, 32'd0);
        bus(1'b1, 32'h00, 32'h1);
        idle(30);
        check("limit_zero_disabled", timeout_o, 1'b0);
        bus(1'b1, 32'h0C, 32'd5);
        check("limit_shrink", {r_to, timeout_o}, 2'b01);

        // Back-to-back requests: ready drops while the response is out
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h04;
        @(posedge clk_i); #1;
        check("b2b_first", {rsp_valid_o, req_ready_o, rsp_rdata_o}, {1'b1, 1'b0, 32'h2});
        @(posedge clk_i); #1;
        check("b2b_stall", {rsp_valid_o, req_ready_o}, 2'b01);
        @(posedge clk_i); #1;
        check("b2b_second", {rsp_valid_o, req_ready_o}, 2'b10);
        req_valid_i = 1'b0;
        idle(1);

        // Asynchronous reset while running with a response in flight
        bus(1'b1, 32'h00, 32'h2);
        bus(1'b1, 32'h0C, 32'd200);
        bus(1'b1, 32'h00, 32'h1);
        idle(5);
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h10;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("pending_rsp", {rsp_valid_o, rsp_rdata_o != 32'd0}, 2'b11);
        #2 rst_ni = 1'b0;
        #1;
        check("async_reset", {rsp_valid_o, rsp_error_o, rsp_rdata_o, eoc_o, timeout_o, irq_o, exit_code_o}, 67'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        bus(1'b0, 32'h04, 32'h0);
        check("post_reset_status", r_data, 32'h0);
        bus(1'b0, 32'h0C, 32'h0);
        check("post_reset_limit", r_data, 32'h0);

        // Randomized traffic against the reference model
        m_done = 0; m_to = 0; m_run = 0; m_count = 0; m_limit = 0; m_code = '0;
        for (int i = 0; i < 400; i++) begin
            int          idx;
            bit          w;
            logic [31:0] a, d;
            idx = int'($urandom_range(0, 7));
            w   = ($urandom_range(0, 3) != 0);
            case (idx)
                0:       d = $urandom_range(0, 3);
                2:       d = ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 3) == 0);
                3:       d = $urandom_range(0, 40);
                default: d = $urandom;
            endcase
            a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a | 32'h20;
            rcycle(1'b1, w, a, d);
            repeat ($urandom_range(1, 6)) rcycle(1'b0, 1'b0, 32'h0, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
